x_400_mod_503_loader: RTL and testbench



---
 rtl/x_400_mod_503_loader.sv | 99 +++++++++
 tb/tb_x_400_mod_503_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/x_400_mod_503_loader.sv
// Framing stage for the 400-bit mod-503 reducer: packs 16-bit words into X,
// captures the returned residue and offers it on a valid/ready result port.
module x_400_mod_503_loader #(
    parameter int W_IN   = 16,
    parameter int N_BITS = 400,
    parameter int MOD    = 503
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic [W_IN-1:0]   in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [N_BITS:1]   x_o,
    input  logic [8:0]        r_in_i,
    output logic [8:0]        res_data_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              range_err_o
);
    localparam int N_WORDS = N_BITS / W_IN;
    localparam int CW      = $clog2(N_WORDS);
    localparam logic [CW-1:0] LAST  = CW'(N_WORDS - 1);
    localparam logic [8:0]    MOD_V = 9'(MOD);

    typedef enum logic [1:0] {
        S_LOAD,
        S_CALC,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_BITS:1] x_q, x_d;
    logic [8:0]      res_q, res_d;
    logic            err_q, err_d;
    logic            rdy_q, rdy_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            x_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            res_q   <= res_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        res_d   = res_q;
        err_d   = err_q;
        if (flush_i) begin
            state_d = S_LOAD;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    // rdy_q gates the handshake so nothing lands in the cycle right after reset
                    if (in_valid_i && rdy_q) begin
                        x_d[W_IN * int'(cnt_q) + 1 +: W_IN] = in_data_i;
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = S_CALC;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    res_d   = r_in_i;
                    err_d   = err_q | (r_in_i >= MOD_V);
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready_i) state_d = S_LOAD;
                end
                default: state_d = S_LOAD;
            endcase
        end
        rdy_d = (state_d == S_LOAD);
    end

    assign in_ready_o  = rdy_q;
    assign x_o         = x_q;
    assign res_data_o  = res_q;
    assign res_valid_o = (state_q == S_HOLD);
    assign range_err_o = err_q;
endmodule

// File: tb/tb_x_400_mod_503_loader.sv
// Bench for the mod-503 loader: directed vector table, hold/flush/reset corners,
// and random operands checked against a word-level residue model.
module tb_x_400_mod_503_loader;
    typedef logic [15:0] op_t [25];
    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        int          exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, res_valid, res_ready, range_err;
    logic [15:0]  in_data;
    logic [400:1] x;
    logic [8:0]   r_in, res_data;
    logic         r_force;
    int           n_pass = 0;
    int           n_total = 0;

    x_400_mod_503_loader dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .x_o(x), .r_in_i(r_in), .res_data_o(res_data),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .range_err_o(range_err)
    );

    always #5 clk = ~clk;

    // Reducer stand-in: bitwise long division of X by 503
    function automatic logic [8:0] x_mod(input logic [400:1] v);
        int r = 0;
        for (int i = 400; i >= 1; i--) r = (r * 2 + int'(v[i])) % 503;
        return 9'(r);
    endfunction
    assign r_in = r_force ? 9'd503 : x_mod(x);

    // Reference: operand value mod 503 from its words, most significant first
    function automatic int ref_mod(input op_t w);
        int r = 0;
        for (int k = 24; k >= 0; k--) r = (r * 65536 + int'(w[k])) % 503;
        return r;
    endfunction

    function automatic logic [400:1] ref_x(input op_t w);
        logic [400:1] v = '0;
        for (int k = 0; k < 25; k++) v[16*k+1 +: 16] = w[k];
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_word(input logic [15:0] w);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
    endtask

    task automatic send_operand(input op_t w, input bit gaps);
        for (int k = 0; k < 25; k++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            push_word(w[k]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic wait_result(input string name, input int exp, input bit rnd_ready);
        int t = 0;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_valid"}, res_valid, 1);
        chk(name, res_data, exp);
        if (rnd_ready) repeat ($urandom_range(0, 2)) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({name, "_drop"}, res_valid, 0);
    endtask

    initial begin
        vec_t tbl [7];
        op_t  w;
        tbl[0] = '{16'h01F7, 16'h0000, 0};
        tbl[1] = '{16'h0200, 16'h0000, 9};
        tbl[2] = '{16'hFFFF, 16'h0000, 145};
        tbl[3] = '{16'h0000, 16'h0001, 146};
        tbl[4] = '{16'h01F6, 16'h0000, 502};
        tbl[5] = '{16'h0001, 16'h0001, 147};
        tbl[6] = '{16'h0000, 16'h0000, 0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        res_ready = 1'b0; r_force = 1'b0;
        #1;
        chk("rst_x", x == '0, 1);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_ready_low", in_ready, 0);
        @(negedge clk);
        chk("rel_in_ready_high", in_ready, 1);

        // Directed table with exact latency checks
        foreach (tbl[i]) begin
            foreach (w[k]) w[k] = '0;
            w[0] = tbl[i].w0;
            w[1] = tbl[i].w1;
            send_operand(w, 1'b0);
            chk($sformatf("v%0d_calc_valid", i), res_valid, 0);
            chk($sformatf("v%0d_calc_ready", i), in_ready, 0);
            @(negedge clk);
            chk($sformatf("v%0d_hold_valid", i), res_valid, 1);
            chk($sformatf("v%0d_x", i), x == ref_x(w), 1);
            if (i == 3) begin
                chk("v3_x17", x[17], 1);
                chk("v3_x_only17", x == (400'd1 << 16), 1);
            end
            chk($sformatf("v%0d_err", i), range_err, 0);
            wait_result($sformatf("v%0d_res", i), tbl[i].exp, 1'b0);
        end

        // Back-pressure: result held, offered words ignored
        foreach (w[k]) w[k] = 16'(k * 7 + 3);
        send_operand(w, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_data", res_data, ref_mod(w));
        end
        in_valid = 1'b0;
        wait_result("hold_res", ref_mod(w), 1'b0);
        foreach (w[k]) w[k] = 16'(1000 + k);
        send_operand(w, 1'b0);
        wait_result("after_hold_res", ref_mod(w), 1'b0);

        // Flush mid-LOAD, presented word dropped
        for (int k = 0; k < 12; k++) push_word(16'hFFFF);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_res_valid", res_valid, 0);
        foreach (w[k]) w[k] = '0;
        w[0] = 16'd502;
        send_operand(w, 1'b0);
        wait_result("flush_res", 502, 1'b0);

        // Flush while a result is pending
        w[0] = 16'd77;
        send_operand(w, 1'b0);
        @(negedge clk);
        chk("hflush_pre_valid", res_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("hflush_valid", res_valid, 0);
        chk("hflush_ready", in_ready, 1);

        // Random operands with input gaps and result back-pressure
        for (int n = 0; n < 100; n++) begin
            foreach (w[k]) w[k] = 16'($urandom);
            send_operand(w, 1'b1);
            wait_result($sformatf("rnd%0d", n), ref_mod(w), 1'b1);
        end
        chk("rnd_err", range_err, 0);

        // Out-of-range residue sets the sticky flag
        r_force = 1'b1;
        foreach (w[k]) w[k] = 16'($urandom);
        send_operand(w, 1'b0);
        wait_result("force_res", 503, 1'b0);
        r_force = 1'b0;
        chk("force_err", range_err, 1);
        foreach (w[k]) w[k] = 16'($urandom);
        send_operand(w, 1'b1);
        wait_result("post_force_res", ref_mod(w), 1'b0);
        chk("err_sticky", range_err, 1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("err_after_flush", range_err, 1);

        // Asynchronous reset mid-LOAD
        for (int k = 0; k < 5; k++) push_word(16'h5A5A);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", x == '0, 1);
        chk("arst_res_data", res_data, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_range_err", range_err, 0);
        chk("arst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (w[k]) w[k] = 16'($urandom);
        send_operand(w, 1'b0);
        wait_result("post_rst_res", ref_mod(w), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
